// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file.
// Sweep FSM states and the read-port range check.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } clr_state_t;

  localparam int REG_FILE_MAX_NR = 8;

  function automatic logic nr_in_range(input int nr);
    return (nr >= 1) && (nr <= REG_FILE_MAX_NR);
  endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Soft-clear sequencer: walks the array one entry per cycle.
// Single pass over 2**D entries, then a one-cycle done pulse.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int D = 3
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         clear_req,
  output logic         clr_en,
  output logic [D-1:0] clr_idx,
  output logic         clear_busy,
  output logic         clear_done
);

  localparam logic [D-1:0] LAST = {D{1'b1}};

  clr_state_t   state, state_nxt;
  logic [D-1:0] idx, idx_nxt;

  // state and index registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // next-state, index advance and status outputs
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    clr_en     = 1'b0;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end
      end
      SWEEP: begin
        clr_en     = 1'b1;
        clear_busy = 1'b1;
        if (idx == LAST) begin
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE: begin
        clear_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign clr_idx = idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NR reads, two prioritised writes.
// REG_FILE_BYPASS_EN enables write-through read forwarding.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int W        = 8,
  parameter int D        = 3,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NR-1:0][D-1:0]  raddr,
  output logic [NR-1:0][W-1:0]  rdata,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [D-1:0]          waddr0,
  input  logic [D-1:0]          waddr1,
  input  logic [W-1:0]          wdata0,
  input  logic [W-1:0]          wdata1,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int  N  = 2 ** D;
  localparam bit  ZR = (ZERO_REG != 0);

  if (!nr_in_range(NR)) begin : g_nr_chk
    $error("reg_file_mp: NR out of range");
  end

  logic [W-1:0] mem [N];
  logic         clr_en;
  logic [D-1:0] clr_idx;
  logic         wr0_ok;
  logic         wr1_ok;

  assign wr0_ok = we0 && !(ZR && (waddr0 == '0));
  assign wr1_ok = we1 && !(ZR && (waddr1 == '0));

  reg_file_clear_seq #(
    .D (D)
  ) u_clr (
    .CLK        (CLK),
    .reset      (reset),
    .clear_req  (clear_req),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
  );

  // sweep clear first, then slot 0, then slot 1 (last wins)
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      if (clr_en) mem[clr_idx] <= '0;
      if (wr0_ok) mem[waddr0] <= wdata0;
      if (wr1_ok) mem[waddr1] <= wdata1;
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [W-1:0] rd;

    // per-port read mux with optional forwarding
    always_comb begin
      rd = mem[raddr[p]];
`ifdef REG_FILE_BYPASS_EN
      if (wr1_ok && (waddr1 == raddr[p])) begin
        rd = wdata1;
      end else if (wr0_ok && (waddr0 == raddr[p])) begin
        rd = wdata0;
      end else if (clr_en && (clr_idx == raddr[p])) begin
        rd = '0;
      end
`endif
      if (ZR && (raddr[p] == '0)) rd = '0;
    end

    assign rdata[p] = rd;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (ZERO_REG=1 and =0 copies).
// Expected values come from a bench-side array model and queues.
module tb_reg_file_mp;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            CLK;
  logic            reset;
  logic [1:0][2:0] raddr;
  logic [1:0][7:0] rdata;
  logic [1:0][7:0] rdata_nz;
  logic            we0, we1;
  logic [2:0]      waddr0, waddr1;
  logic [7:0]      wdata0, wdata1;
  logic            clear_req;
  logic            clear_busy, clear_done;
  logic            nz_busy, nz_done;

  int         checks;
  int         errors;
  logic [7:0] m1 [8];
  logic [7:0] m0 [8];
  logic [7:0] q  [$];
  logic [1:0] sq [$];

  reg_file_mp #(.W(8), .D(3), .NR(2), .ZERO_REG(1)) dut (
    .CLK(CLK), .reset(reset), .raddr(raddr), .rdata(rdata),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  reg_file_mp #(.W(8), .D(3), .NR(2), .ZERO_REG(0)) dut_nz (
    .CLK(CLK), .reset(reset), .raddr(raddr), .rdata(rdata_nz),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .clear_req(clear_req),
    .clear_busy(nz_busy), .clear_done(nz_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    we0 = 0; we1 = 0; clear_req = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m1[i] = 8'h00;
      m0[i] = 8'h00;
    end
  endtask

  // model of the currently driven writes, slot 1 applied last
  task automatic commit_model();
    if (we0) begin
      if (waddr0 != 0) m1[waddr0] = wdata0;
      m0[waddr0] = wdata0;
    end
    if (we1) begin
      if (waddr1 != 0) m1[waddr1] = wdata1;
      m0[waddr1] = wdata1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset = 1; idle(); raddr = '0;
    repeat (2) @(negedge CLK);
    reset = 0;
    clear_model();
    for (int a = 0; a < 8; a++) begin
      @(negedge CLK);
      raddr[0] = 3'(a);
      raddr[1] = 3'(7 - a);
      q.push_back(m1[a]);
      q.push_back(m0[7 - a]);
      #1;
      checks++; e = q.pop_front();
      if (rdata[0] !== e) begin
        errors++;
        $display("FAIL reset_rd0 a=%0d got %h want %h", a, rdata[0], e);
      end
      checks++; e = q.pop_front();
      if (rdata_nz[1] !== e) begin
        errors++;
        $display("FAIL reset_rd1 a=%0d got %h want %h", a, rdata_nz[1], e);
      end
    end
    checks++;
    if ({clear_busy, clear_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_status got %b want 00", {clear_busy, clear_done});
    end
    @(negedge CLK);
    we0 = 1; waddr0 = 3'd5; wdata0 = 8'h99;
    commit_model();
    @(negedge CLK);
    idle(); raddr[0] = 3'd5;
    #1;
    checks++;
    if (rdata[0] !== m1[5]) begin
      errors++;
      $display("FAIL pre_async got %h want %h", rdata[0], m1[5]);
    end
    #2 reset = 1;
    clear_model();
    #1;
    checks++;
    if (rdata[0] !== m1[5]) begin
      errors++;
      $display("FAIL async_reset got %h want %h", rdata[0], m1[5]);
    end
    @(negedge CLK);
    reset = 0;
  endtask

  task automatic test_same_addr();
    @(negedge CLK);
    we0 = 1; waddr0 = 3'd3; wdata0 = 8'h5A;
    we1 = 1; waddr1 = 3'd3; wdata1 = 8'hC3;
    commit_model();
    @(negedge CLK);
    idle(); raddr[0] = 3'd3;
    #1;
    checks++;
    if (rdata[0] !== 8'hC3) begin
      errors++;
      $display("FAIL same_addr got %h want %h", rdata[0], 8'hC3);
    end
    @(negedge CLK);
    we0 = 1; waddr0 = 3'd2; wdata0 = 8'h11;
    we1 = 1; waddr1 = 3'd5; wdata1 = 8'h22;
    commit_model();
    @(negedge CLK);
    idle(); raddr[0] = 3'd2; raddr[1] = 3'd5;
    #1;
    checks++;
    if (rdata[0] !== m1[2]) begin
      errors++;
      $display("FAIL dual_wr0 got %h want %h", rdata[0], m1[2]);
    end
    checks++;
    if (rdata[1] !== m1[5]) begin
      errors++;
      $display("FAIL dual_wr1 got %h want %h", rdata[1], m1[5]);
    end
  endtask

  task automatic test_zero_reg();
    logic [7:0] e_nz;
    @(negedge CLK);
    raddr[0] = 3'd0;
    we0 = 1; waddr0 = 3'd0; wdata0 = 8'hFF;
    e_nz = BYP ? 8'hFF : m0[0];
    commit_model();
    #1;
    checks++;
    if (rdata[0] !== 8'h00) begin
      errors++;
      $display("FAIL zero_same got %h want 00", rdata[0]);
    end
    checks++;
    if (rdata_nz[0] !== e_nz) begin
      errors++;
      $display("FAIL nz_same got %h want %h", rdata_nz[0], e_nz);
    end
    @(negedge CLK);
    idle();
    #1;
    checks++;
    if (rdata[0] !== m1[0]) begin
      errors++;
      $display("FAIL zero_next got %h want %h", rdata[0], m1[0]);
    end
    checks++;
    if (rdata_nz[0] !== m0[0]) begin
      errors++;
      $display("FAIL nz_next got %h want %h", rdata_nz[0], m0[0]);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] e;
    @(negedge CLK);
    raddr[1] = 3'd4;
    we0 = 1; waddr0 = 3'd4; wdata0 = 8'h10;
    commit_model();
    @(negedge CLK);
    we0 = 1; waddr0 = 3'd4; wdata0 = 8'h77;
    e = BYP ? 8'h77 : m1[4];
    commit_model();
    #1;
    checks++;
    if (rdata[1] !== e) begin
      errors++;
      $display("FAIL bypass_same got %h want %h", rdata[1], e);
    end
    @(negedge CLK);
    idle();
    #1;
    checks++;
    if (rdata[1] !== 8'h77) begin
      errors++;
      $display("FAIL bypass_next got %h want 77", rdata[1]);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] es;
    logic [7:0] e;
    for (int a = 0; a < 8; a++) begin
      @(negedge CLK);
      we0 = 1; waddr0 = 3'(a); wdata0 = 8'hAA;
      commit_model();
    end
    @(negedge CLK);
    idle();
    clear_req = 1;
    for (int c = 1; c <= 12; c++)
      sq.push_back({(c <= 8) ? 1'b1 : 1'b0, (c == 9) ? 1'b1 : 1'b0});
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      idle();
      if (c == 3) begin
        we0 = 1; waddr0 = 3'd1; wdata0 = 8'h33;
        we1 = 1; waddr1 = 3'd6; wdata1 = 8'h44;
      end
      if (c == 5) clear_req = 1;
      if (c == 4) begin
        raddr[0] = 3'd3; raddr[1] = 3'd7;
        q.push_back(BYP ? 8'h00 : m1[3]);
        q.push_back(m1[7]);
      end
      if (c <= 8) begin
        m1[c - 1] = 8'h00;
        m0[c - 1] = 8'h00;
      end
      commit_model();
      #1;
      checks++; es = sq.pop_front();
      if ({clear_busy, clear_done} !== es) begin
        errors++;
        $display("FAIL sweep_status c=%0d got %b want %b",
                 c, {clear_busy, clear_done}, es);
      end
      if (c == 4) begin
        checks++; e = q.pop_front();
        if (rdata[0] !== e) begin
          errors++;
          $display("FAIL sweep_rd_idx got %h want %h", rdata[0], e);
        end
        checks++; e = q.pop_front();
        if (rdata[1] !== e) begin
          errors++;
          $display("FAIL sweep_rd_live got %h want %h", rdata[1], e);
        end
      end
    end
    for (int a = 0; a < 8; a++) begin
      @(negedge CLK);
      raddr[0] = 3'(a);
      raddr[1] = 3'(a);
      #1;
      checks++;
      if (rdata[0] !== m1[a]) begin
        errors++;
        $display("FAIL post_sweep a=%0d got %h want %h", a, rdata[0], m1[a]);
      end
      checks++;
      if (rdata_nz[1] !== m0[a]) begin
        errors++;
        $display("FAIL post_sweep_nz a=%0d got %h want %h",
                 a, rdata_nz[1], m0[a]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge CLK);
    we0 = 1; waddr0 = 3'd7; wdata0 = 8'h5C;
    commit_model();
    @(negedge CLK);
    idle();
    clear_req = 1;
    raddr[0] = 3'd7;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      idle();
    end
    #2 reset = 1;
    clear_model();
    #1;
    checks++;
    if ({clear_busy, clear_done} !== 2'b00) begin
      errors++;
      $display("FAIL abort_status got %b want 00", {clear_busy, clear_done});
    end
    checks++;
    if (rdata[0] !== m1[7]) begin
      errors++;
      $display("FAIL abort_data got %h want %h", rdata[0], m1[7]);
    end
    @(negedge CLK);
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({clear_busy, clear_done} !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_done c=%0d got %b want 00",
                 c, {clear_busy, clear_done});
      end
    end
    for (int a = 0; a < 8; a++) begin
      @(negedge CLK);
      raddr[1] = 3'(a);
      #1;
      checks++;
      if (rdata_nz[1] !== m0[a]) begin
        errors++;
        $display("FAIL abort_clear a=%0d got %h want %h", a, rdata_nz[1], m0[a]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_same_addr();
    test_zero_reg();
    test_bypass();
    test_sweep();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
